// File: rtl/fifo_ch_scheduler_if.sv
// Signal bundle between the two load channels / FIFO flags and fifo_ch_scheduler.
// Handshake: a request is a level; the scheduler answers with a grant and drives fifo_wr/fifo_rd itself.
interface fifo_ch_scheduler_if #(
    parameter int BURST_W = 4
) ();
    logic               req_ch1;
    logic               req_ch2;
    logic [BURST_W-1:0] burst_len;
    logic               fifo_full;
    logic               fifo_empty;
    logic               mux_sel;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               gnt_ch1;
    logic               gnt_ch2;
    logic               ready;
    logic               err_timeout;

    modport master (
        output req_ch1, req_ch2, burst_len, fifo_full, fifo_empty,
        input  mux_sel, fifo_wr, fifo_rd, gnt_ch1, gnt_ch2, ready, err_timeout
    );

    modport slave (
        input  req_ch1, req_ch2, burst_len, fifo_full, fifo_empty,
        output mux_sel, fifo_wr, fifo_rd, gnt_ch1, gnt_ch2, ready, err_timeout
    );
endinterface

// File: rtl/fifo_ch_scheduler.sv
// Two-channel FIFO load/drain scheduler: round-robin burst loads into a FIFO, then drains it.
// Optional DRAIN watchdog enabled by defining SCHED_TIMEOUT_EN.
module fifo_ch_scheduler #(
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    fifo_ch_scheduler_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam logic CH1 = 1'b1;
    localparam logic CH2 = 1'b0;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;

    logic rdy, wr, rd, msel, g1, g2;

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= CH2;
            last_owner_q <= CH2;
            cnt_q        <= '0;
`ifdef SCHED_TIMEOUT_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
`ifdef SCHED_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        rdy          = 1'b0;
        wr           = 1'b0;
        rd           = 1'b0;
        msel         = 1'b0;
        g1           = 1'b0;
        g2           = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        wdog_d       = '0;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.req_ch1 || bus.req_ch2) begin
                    state_d = LOAD;
                    // Contention goes to whoever did not own the previous burst.
                    owner_d = (bus.req_ch1 && bus.req_ch2) ? ~last_owner_q : bus.req_ch1;
                    cnt_d   = bus.burst_len;
                end
            end
            LOAD: begin
                wr   = ~bus.fifo_full;
                msel = (owner_q == CH1);
                g1   = (owner_q == CH1);
                g2   = (owner_q == CH2);
                if (!bus.fifo_full) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // A zero load count wraps, so burst_len==0 yields 2^BURST_W beats.
                if (bus.fifo_full || (cnt_q == BURST_W'(1))) begin
                    state_d      = DRAIN;
                    last_owner_d = owner_q;
                end
            end
            DRAIN: begin
                rd = ~bus.fifo_empty;
                if (bus.fifo_empty) begin
                    state_d = IDLE;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready   = rdy;
    assign bus.fifo_wr = wr;
    assign bus.fifo_rd = rd;
    assign bus.mux_sel = msel;
    assign bus.gnt_ch1 = g1;
    assign bus.gnt_ch2 = g2;
`ifdef SCHED_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fifo_ch_scheduler.sv
// Self-checking bench for fifo_ch_scheduler: directed scenarios plus random traffic
// compared cycle by cycle with a burst-level reference model.
module tb_fifo_ch_scheduler;
    localparam int BW  = 4;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fifo_ch_scheduler_if #(.BURST_W(BW)) bus ();

    fifo_ch_scheduler #(.BURST_W(BW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Reference model: phase 0 = idle, 1 = writing a burst, 2 = draining.
    int m_phase, m_left, m_owner, m_last, m_dcnt;
    bit m_err;

    int n_checks, n_errors;
    int n_wr, n_rd, n_err, n_grants;
    bit prev_gnt;
    logic [1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = 2;
        m_last   = 2;
        m_left   = 0;
        m_dcnt   = 0;
        m_err    = 1'b0;
        prev_gnt = 1'b0;
    endtask

    task automatic model_update(input bit r1, input bit r2, input int bl, input bit full, input bit empty);
        m_err = 1'b0;
        case (m_phase)
            0: if (r1 || r2) begin
                if (r1 && r2) m_owner = (m_last == 1) ? 2 : 1;
                else          m_owner = r1 ? 1 : 2;
                m_left  = (bl == 0) ? (1 << BW) : bl;
                m_phase = 1;
            end
            1: begin
                if (!full) m_left--;
                if (full || m_left == 0) begin
                    m_phase = 2;
                    m_last  = m_owner;
                    m_dcnt  = 0;
                end
            end
            default: begin
                if (empty) m_phase = 0;
                else begin
                    m_dcnt++;
`ifdef SCHED_TIMEOUT_EN
                    if (m_dcnt == TMO) begin
                        m_phase = 0;
                        m_err   = 1'b1;
                    end
`endif
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        bit full, empty, cur;
        full  = bus.fifo_full;
        empty = bus.fifo_empty;
        check_eq("ready",   32'(bus.ready),       32'(m_phase == 0));
        check_eq("fifo_wr", 32'(bus.fifo_wr),     32'(m_phase == 1 && !full));
        check_eq("fifo_rd", 32'(bus.fifo_rd),     32'(m_phase == 2 && !empty));
        check_eq("mux_sel", 32'(bus.mux_sel),     32'(m_phase == 1 && m_owner == 1));
        check_eq("gnt_ch1", 32'(bus.gnt_ch1),     32'(m_phase == 1 && m_owner == 1));
        check_eq("gnt_ch2", 32'(bus.gnt_ch2),     32'(m_phase == 1 && m_owner == 2));
        check_eq("err_tmo", 32'(bus.err_timeout), 32'(m_err));
        check_eq("wr_rd_excl", 32'(bus.fifo_wr & bus.fifo_rd), 32'(0));
        n_wr  += int'(bus.fifo_wr);
        n_rd  += int'(bus.fifo_rd);
        n_err += int'(bus.err_timeout);
        cur = bus.gnt_ch1 | bus.gnt_ch2;
        if (cur && !prev_gnt) begin
            n_grants++;
            if (exp_q.size() > 0) check_eq("grant_order", bus.gnt_ch1 ? 32'd1 : 32'd2, 32'(exp_q.pop_front()));
        end
        prev_gnt = cur;
    endtask

    // Called at posedge+1: drive, check before the next edge, then advance the model.
    task automatic step(input bit r1, input bit r2, input int bl, input bit full, input bit empty);
        bus.req_ch1    = r1;
        bus.req_ch2    = r2;
        bus.burst_len  = BW'(bl);
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        #2;
        check_outputs();
        @(posedge clk);
        model_update(r1, r2, bl, full, empty);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            bus.req_ch1    = 1'($urandom_range(0, 1));
            bus.req_ch2    = 1'($urandom_range(0, 1));
            bus.burst_len  = BW'($urandom_range(0, 15));
            bus.fifo_full  = 1'($urandom_range(0, 1));
            bus.fifo_empty = 1'($urandom_range(0, 1));
            #2;
            check_outputs();
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic clear_tallies();
        n_wr = 0; n_rd = 0; n_err = 0; n_grants = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.req_ch1 = 0; bus.req_ch2 = 0; bus.burst_len = '0;
        bus.fifo_full = 0; bus.fifo_empty = 1;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with random inputs, then idle with no requests.
        apply_reset(4);
        for (int i = 0; i < 3; i++) step(0, 0, 3, 0, 1);

        // Single channel, burst of 3, three reads before empty.
        clear_tallies();
        for (int i = 0; i < 9; i++) step(i == 0, 0, 3, 0, i >= 7);
        check_eq("single_wr_count", 32'(n_wr), 32'd3);
        check_eq("single_rd_count", 32'(n_rd), 32'd3);

        // Round-robin with both channels held.
        apply_reset(1);
        clear_tallies();
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        for (int i = 0; i < 16; i++) step(1, 1, 2, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 2, 0, 1);
        check_eq("rr_grants", 32'(n_grants), 32'd4);
        check_eq("rr_wr_count", 32'(n_wr), 32'd8);
        check_eq("rr_queue_left", 32'(exp_q.size()), 32'd0);

        // Early full after two writes of a five-word burst.
        apply_reset(1);
        clear_tallies();
        for (int i = 0; i < 8; i++) step(i == 0, 0, 5, i >= 3, i >= 6);
        check_eq("early_full_wr", 32'(n_wr), 32'd2);
        check_eq("early_full_rd", 32'(n_rd), 32'd2);

        // burst_len 0 wraps to 16 beats; later burst_len changes and request drop are ignored.
        apply_reset(1);
        clear_tallies();
        for (int i = 0; i < 20; i++) step(i == 0, 0, (i == 0) ? 0 : int'($urandom_range(1, 15)), 0, 1);
        check_eq("wrap_wr_count", 32'(n_wr), 32'd16);
        check_eq("wrap_rd_count", 32'(n_rd), 32'd0);

        // DRAIN with the FIFO never emptying.
        apply_reset(1);
        clear_tallies();
        for (int i = 0; i < 16; i++) step(i == 0, 0, 1, 0, 0);
        check_eq("tmo_wr_count", 32'(n_wr), 32'd1);
`ifdef SCHED_TIMEOUT_EN
        check_eq("tmo_rd_count", 32'(n_rd), 32'(TMO));
        check_eq("tmo_err_pulses", 32'(n_err), 32'd1);
`else
        check_eq("tmo_rd_count", 32'(n_rd), 32'd14);
        check_eq("tmo_err_pulses", 32'(n_err), 32'd0);
`endif

        // Random traffic with occasional mid-operation reset.
        apply_reset(1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset(1);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
